// File: rtl/kyber_pkg.sv
// Shared constants and per-stage tag layouts for the Kyber coefficient datapath.
package kyber_pkg;

  localparam int KYBER_WIDTH   = 16;
  localparam int KYBER_Q       = 3329;
  localparam int KYBER_QINV    = -3327;
  localparam int KYBER_MONT_R2 = 1353;
  localparam int KYBER_N_COEF  = 256;

  typedef enum logic {
    MODE_TOMONT   = 1'b0,
    MODE_FROMMONT = 1'b1
  } mont_mode_e;

  // Tag travelling with a coefficient through the operand-select stage.
  typedef struct packed {
    logic       valid;
    mont_mode_e mode;
    logic       last;
  } stage_tag_t;

  // Past operand select the mode has been consumed; only valid/last remain.
  typedef struct packed {
    logic valid;
    logic last;
  } pipe_tag_t;

endpackage

// File: rtl/kyber_mont_reduce_pipe.sv
// Two-stage signed Montgomery reduction r = p * 2^-WIDTH mod q, result in (-q, q).
module kyber_mont_reduce_pipe
  import kyber_pkg::*;
#(
  parameter int WIDTH = KYBER_WIDTH,
  parameter int Q     = KYBER_Q,
  parameter int QINV  = KYBER_QINV
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic signed [2*WIDTH-1:0] p,
  output logic signed [WIDTH-1:0]   r
);

  localparam logic signed [WIDTH-1:0]   QINV_W = WIDTH'(QINV);
  localparam logic signed [2*WIDTH-1:0] Q_W    = (2*WIDTH)'(Q);

  logic signed [2*WIDTH-1:0] p_q;
  logic signed [2*WIDTH-1:0] tq;
  logic signed [2*WIDTH-1:0] diff;
  logic signed [WIDTH-1:0]   t_next;
  logic signed [WIDTH-1:0]   t_q;

  always_comb begin
    t_next = $signed(p[WIDTH-1:0]) * QINV_W;
    tq     = (2*WIDTH)'(t_q) * Q_W;
    // Low half of diff is exactly zero, so the shift loses nothing.
    diff   = p_q - tq;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q <= '0;
      t_q <= '0;
      r   <= '0;
    end else if (en) begin
      p_q <= p;
      t_q <= t_next;
      r   <= WIDTH'(diff >>> WIDTH);
    end
  end

endmodule

// File: rtl/kyber_mont_convert.sv
// Streaming normal<->Montgomery coefficient converter with frame tagging.
// Define KYBER_MONT_CANON_OUT_EN to add a stage that folds results into [0, q).
module kyber_mont_convert #(
  parameter int WIDTH   = 16,
  parameter int KYBER_Q = kyber_pkg::KYBER_Q,
  parameter int N_COEF  = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode_i,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    busy
);
  import kyber_pkg::*;

  localparam int CW = $clog2(N_COEF);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_COEF - 1);
  localparam logic signed [2*WIDTH-1:0] R2_W = (2*WIDTH)'(KYBER_MONT_R2);

  logic [CW-1:0]             in_cnt;
  mont_mode_e                mode_q;
  mont_mode_e                mode_cur;
  stage_tag_t                s1_tag;
  logic signed [WIDTH-1:0]   s1_a;
  pipe_tag_t                 s2_tag;
  pipe_tag_t                 s3_tag;
  logic signed [WIDTH-1:0]   r3;
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] p1;
  logic                      adv;
  logic                      acc;
  logic                      tail_busy;

  always_comb begin
    adv      = m_ready | ~m_valid;
    s_ready  = adv;
    acc      = s_valid & adv;
    mode_cur = (in_cnt == '0) ? mont_mode_e'(mode_i) : mode_q;
    a_ext    = {{WIDTH{s1_a[WIDTH-1]}}, s1_a};
    p1       = (s1_tag.mode == MODE_FROMMONT) ? a_ext : a_ext * R2_W;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_cnt <= '0;
      mode_q <= MODE_TOMONT;
      s1_tag <= '0;
      s1_a   <= '0;
      s2_tag <= '0;
      s3_tag <= '0;
    end else begin
      if (acc) begin
        in_cnt <= (in_cnt == LAST_IDX) ? '0 : in_cnt + 1'b1;
        if (in_cnt == '0) mode_q <= mont_mode_e'(mode_i);
      end
      if (adv) begin
        s1_tag <= '{valid: acc, mode: mode_cur, last: (in_cnt == LAST_IDX)};
        s1_a   <= s_data;
        s2_tag <= '{valid: s1_tag.valid, last: s1_tag.last};
        s3_tag <= s2_tag;
      end
    end
  end

  kyber_mont_reduce_pipe #(
    .WIDTH (WIDTH),
    .Q     (KYBER_Q),
    .QINV  (KYBER_QINV)
  ) u_reduce (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .p     (p1),
    .r     (r3)
  );

`ifdef KYBER_MONT_CANON_OUT_EN
  localparam logic signed [WIDTH-1:0] Q_W = WIDTH'(KYBER_Q);

  pipe_tag_t               s4_tag;
  logic signed [WIDTH-1:0] r4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s4_tag <= '0;
      r4     <= '0;
    end else if (adv) begin
      s4_tag <= s3_tag;
      r4     <= r3 + (r3[WIDTH-1] ? Q_W : '0);
    end
  end

  always_comb begin
    m_valid   = s4_tag.valid;
    m_last    = s4_tag.last;
    m_data    = r4;
    tail_busy = s3_tag.valid | s4_tag.valid;
  end
`else
  always_comb begin
    m_valid   = s3_tag.valid;
    m_last    = s3_tag.last;
    m_data    = r3;
    tail_busy = s3_tag.valid;
  end
`endif

  always_comb begin
    busy = s1_tag.valid | s2_tag.valid | tail_busy | (in_cnt != '0);
  end

endmodule

// File: doc/kyber_mont_convert.md
Name: kyber_mont_convert

Overview:
- Streaming converter between the normal and Montgomery coefficient domains for Kyber polynomials.
- tomont: r = a·2^16 mod q. frommont: r = a·2^-16 mod q.
- Sits in the NTT datapath between coefficient RAM read-out and the butterfly/pointwise units, alongside the Barrett reducer.
- Uses valid/ready handshakes, a pipelined signed Montgomery reduction, per-coefficient mode tagging and frame (polynomial) framing.

Parameters:
- WIDTH, 16: coefficient width, signed two's complement.
- KYBER_Q, 3329: modulus q.
- N_COEF, 256: coefficients per polynomial frame.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- mode_i  in  1  0 = tomont, 1 = frommont; sampled only on the first accepted coefficient of a frame.
- s_valid  in  1  input coefficient valid.
- s_ready  out  1  input ready.
- s_data  in  WIDTH  signed input coefficient, any int16 value.
- m_valid  out  1  output coefficient valid.
- m_ready  in  1  downstream ready.
- m_data  out  WIDTH  signed result.
- m_last  out  1  marks coefficient N_COEF-1 of a frame.
- busy  out  1  high while any pipeline stage holds valid data or in_cnt != 0.

Behaviour:
- Reset (rst_n=0 at a clk edge): all stage valids=0, m_valid=0, m_data=0, m_last=0, in_cnt=0, frame mode register=0, busy=0.
  - Reset mid-frame discards all in-flight data; the next accepted coefficient starts a new frame.
- Handshake:
  - Transfer occurs when valid && ready.
  - adv = m_ready | ~m_valid. s_ready = adv; s_ready is registered-free combinational from m_ready and the m_valid register.
  - All stages shift together when adv=1 and hold when adv=0.
  - m_data/m_valid/m_last stay stable while m_valid && !m_ready.
- Framing:
  - in_cnt (log2 N_COEF bits) increments per accepted input and wraps N_COEF-1 → 0.
  - When in_cnt==0 on acceptance, mode_i is latched and tags that coefficient; later coefficients use the latched mode.
  - mode_i changes mid-frame are ignored.
  - Each stage carries {valid, mode, last, data}. last = (in_cnt==N_COEF-1) at acceptance.
  - Back-to-back frames with different modes need no bubble.
- Arithmetic (all signed):
  - S1: p = (mode ? sext32(a) : a*1353) as 32-bit, where 1353 = 2^32 mod q.
  - S2: t = int16(p[15:0]·QINV), with QINV = -3327; keep p.
  - S3: r = (p − t·q) >>> 16. Result lies in (−q, q), and p[15:0] − (t·q)[15:0] = 0 exactly.
- Latency: 3 cycles from acceptance to m_valid with m_ready held high. Throughput: 1 coefficient per cycle.

Optional Feature:
- Macro: KYBER_MONT_CANON_OUT_EN.
- Defined: adds stage S4 with r' = r + (r<0 ? q : 0), so the output is canonical in [0, q). Latency becomes 4; handshake, framing and m_last alignment are unchanged.
- Undefined: raw Montgomery output in (−q, q), latency 3.

Decomposition:
- kyber_pkg holds KYBER_Q, KYBER_QINV (−3327), KYBER_MONT_R2 (1353), the WIDTH localparam, and the per-stage tag struct/packed layout {valid, mode, last}.
- One natural sub-module: kyber_mont_reduce_pipe, the 2-stage S2/S3 Montgomery reduction with an enable input. It is reusable by the pointwise multiplier.
- The top level keeps S1, the counter/framing logic and the handshake.

Test Plan:
- tomont, m_ready=1: s_data=1 → m_data=−1044 three cycles later (2285 with CANON). s_data=0 → 0.
- frommont: first frame coefficient 2285 → 1. Coefficient −1044 → 1. Coefficient 0 → 0.
- Full 256-coefficient tomont frame followed immediately by a frommont frame, toggling mode_i mid-frame:
  - m_last asserts exactly on output index 255 and 511.
  - Mode switches only at the frame boundary.
  - Round trip frommont(tomont(x)) ≡ x mod q for random x.
- Backpressure: random m_ready with 30% low duty → no loss or duplication, output order preserved, m_data stable while stalled, s_ready=0 only when m_valid && !m_ready.
- Extremes: s_data = −32768, 32767 and ±3329 in both modes → result in (−q, q) and congruent to the reference model.
- Reset at coefficient 100 with a full pipeline → next cycle m_valid=0 and busy=0; the next frame's m_last appears on its 256th output.
